adc_frame_sender: RTL

- Read-side drain engine for the ADC capture FIFO; runs entirely in the FIFO read-clock domain.
- When the capture path reports a full buffer, it latches the captured length and reads every sample out of the FIFO.
- It wraps the samples in a fixed frame (sync word, length, payload, optional checksum) and hands the frame byte-by-byte to the SPI transmit stage over a valid/ready handshake.
- It then pulses the FIFO clear so the capture path re-arms its trigger.

---
 rtl/adc_frame_sender.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adc_frame_sender.sv
// adc_frame_sender: drains the ADC capture FIFO into a sync/length/payload frame over valid/ready; ADC_FRAME_CHECKSUM_EN adds a trailing sum byte
module adc_frame_sender #(
  parameter int          LEN_W   = 16,
  parameter int          MAX_LEN = 4096,
  parameter logic [7:0]  SYNC0   = 8'hA5,
  parameter logic [7:0]  SYNC1   = 8'h5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send_en,
  input  logic [31:0] len,
  input  logic [7:0]  fifo_q,
  output logic        fifo_rd,
  output logic        fifo_clear,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);
  typedef enum logic [3:0] {
    IDLE, HDR0, HDR1, LEN_HI, LEN_LO, FETCH, WAITQ, PAYLOAD, DONE, HOLD
`ifdef ADC_FRAME_CHECKSUM_EN
    , CSUM
`endif
  } state_t;
  state_t           r_state;
  logic [LEN_W-1:0] r_n;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_fifo_rd;
  logic             r_fifo_clear;
  logic             r_frame_done;
  logic             r_busy;
`ifdef ADC_FRAME_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif
  logic             w_hi;
  logic [LEN_W-1:0] w_lo;
  logic [LEN_W-1:0] w_n;
  logic [15:0]      w_len16;
  logic             w_xfer;
  logic             w_last;
  assign w_hi    = (len >> LEN_W) != 32'd0;
  assign w_lo    = len[LEN_W-1:0];
  assign w_n     = (w_hi || w_lo > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : w_lo;
  assign w_len16 = 16'(r_n);
  assign w_xfer  = r_tx_valid & tx_ready;
  assign w_last  = r_cnt == LEN_W'(1);
  assign fifo_rd    = r_fifo_rd;
  assign fifo_clear = r_fifo_clear;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  // frame sequencer: every output is registered and set on the transition into the state that owns it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_n          <= '0;
      r_cnt        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_fifo_rd    <= 1'b0;
      r_fifo_clear <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (send_en) begin
          r_n        <= w_n;
          r_cnt      <= w_n;
`ifdef ADC_FRAME_CHECKSUM_EN
          r_csum     <= '0;
`endif
          r_tx_data  <= SYNC0;
          r_tx_valid <= 1'b1;
          r_busy     <= 1'b1;
          r_state    <= HDR0;
        end
        HDR0: if (w_xfer) begin
          r_tx_data <= SYNC1;
          r_state   <= HDR1;
        end
        HDR1: if (w_xfer) begin
          r_tx_data <= w_len16[15:8];
          r_state   <= LEN_HI;
        end
        LEN_HI: if (w_xfer) begin
          r_tx_data <= w_len16[7:0];
          r_state   <= LEN_LO;
        end
        LEN_LO: if (w_xfer) begin
          if (r_n != '0) begin
            r_tx_valid <= 1'b0;
            r_fifo_rd  <= 1'b1;
            r_state    <= FETCH;
          end else begin
`ifdef ADC_FRAME_CHECKSUM_EN
            r_tx_data    <= r_csum;
            r_state      <= CSUM;
`else
            r_tx_valid   <= 1'b0;
            r_fifo_clear <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= DONE;
`endif
          end
        end
        FETCH: begin
          r_fifo_rd <= 1'b0;
          r_state   <= WAITQ;
        end
        WAITQ: begin
          r_tx_data  <= fifo_q;
`ifdef ADC_FRAME_CHECKSUM_EN
          r_csum     <= r_csum + fifo_q;
`endif
          r_tx_valid <= 1'b1;
          r_state    <= PAYLOAD;
        end
        PAYLOAD: if (w_xfer) begin
          r_cnt <= r_cnt - LEN_W'(1);
          if (!w_last) begin
            r_tx_valid <= 1'b0;
            r_fifo_rd  <= 1'b1;
            r_state    <= FETCH;
          end else begin
`ifdef ADC_FRAME_CHECKSUM_EN
            r_tx_data    <= r_csum;
            r_state      <= CSUM;
`else
            r_tx_valid   <= 1'b0;
            r_fifo_clear <= 1'b1;
            r_frame_done <= 1'b1;
            r_state      <= DONE;
`endif
          end
        end
`ifdef ADC_FRAME_CHECKSUM_EN
        CSUM: if (w_xfer) begin
          r_tx_valid   <= 1'b0;
          r_fifo_clear <= 1'b1;
          r_frame_done <= 1'b1;
          r_state      <= DONE;
        end
`endif
        DONE: begin
          r_fifo_clear <= 1'b0;
          r_frame_done <= 1'b0;
          r_state      <= HOLD;
        end
        HOLD: if (!send_en) begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
